// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e               receiver FSM states
//   PAR_NONE/PAR_ODD/PAR_EVEN parity mode encodings
//   UART_CLKS_PER_BIT_115200 bit period at 25 MHz, shared with the baud divider
//   parity_bit()             expected parity bit for a byte under a given mode
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned UART_CLKS_PER_BIT_115200 = 217;

  // Even parity: XOR of the data bits; odd parity: its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk_i  sampling clock
//   rst_i  synchronous active-high reset, loads RESET_VAL into both flops
//   d_i    asynchronous input
//   q_o    synchronized output, two cycles behind d_i
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Samples the synchronized line once at mid-bit using a bit-period counter.
//   clk_in      25 MHz system clock
//   reset       synchronous active-high reset
//   rx_in       asynchronous serial line, idle high
//   rx_data     last received byte, held until the next frame completes
//   rx_valid    one-cycle strobe per completed frame (also on errors)
//   frame_err   stop bit sampled low, updated with rx_valid
//   parity_err  parity mismatch, updated with rx_valid
//   busy        high whenever the receiver is not idle
//
// state | meaning
// IDLE  | waiting for rx_s to go low
// START | checking the start bit at half a bit period
// DATA  | sampling 8 data bits, one per bit period
// PAR   | sampling the parity bit
// STOP  | sampling the stop bit, completing the frame
// BREAK | line held low after a bad stop bit; wait for it to go high
module uart_rx import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int unsigned PARITY       = PAR_NONE
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1     = CW'(CLKS_PER_BIT - 1);
  localparam bit            HAS_PARITY = (PARITY != PAR_NONE);

  logic rx_s;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk_in),
    .rst_i (reset),
    .d_i   (rx_in),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  // The counter clears on every transition and at every sample point, so each
  // sample lands exactly CLKS_PER_BIT cycles after the previous one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          // Right shift: after eight samples the first bit sits in bit 0.
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = HAS_PARITY ? PAR : STOP;
        end
      end
      PAR: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          ferr_d  = ~rx_s;
          perr_d  = HAS_PARITY && (par_q != parity_bit(shift_q, PARITY));
          state_d = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: channel 0 runs without parity, channel 1 with even parity.
// Frames are pushed to a per-channel expectation queue with the strobe cycle
// computed from the frame timing; a compare thread checks the outputs each cycle.
module tb_uart_rx;

  localparam int unsigned CPB  = 217;
  localparam int unsigned HALF = CPB / 2;

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  data;
    logic        ferr;
    logic        perr;
  } exp_t;

  logic       clk_in;
  logic       reset;
  logic       rx_line  [2];
  logic [7:0] data_w   [2];
  logic       valid_w  [2];
  logic       ferr_w   [2];
  logic       perr_w   [2];
  logic       busy_w   [2];

  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_fail;
  bit          en;

  exp_t        expq [2][$];
  logic [7:0]  hold_data [2];
  logic        hold_fe   [2];
  logic        hold_pe   [2];
  int unsigned last_strobe [2];
  int unsigned prev_strobe [2];
  logic        busy_at_strobe   [2];
  logic        busy_before_strb [2];
  logic        prev_busy [2];

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_dut_n (
    .clk_in     (clk_in),
    .reset      (reset),
    .rx_in      (rx_line[0]),
    .rx_data    (data_w[0]),
    .rx_valid   (valid_w[0]),
    .frame_err  (ferr_w[0]),
    .parity_err (perr_w[0]),
    .busy       (busy_w[0])
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_dut_e (
    .clk_in     (clk_in),
    .reset      (reset),
    .rx_in      (rx_line[1]),
    .rx_data    (data_w[1]),
    .rx_valid   (valid_w[1]),
    .frame_err  (ferr_w[1]),
    .parity_err (perr_w[1]),
    .busy       (busy_w[1])
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic compare_cycle();
    exp_t e;
    bit   due;
    for (int ch = 0; ch < 2; ch++) begin
      due = (expq[ch].size() != 0) && (expq[ch][0].cyc == cyc);
      if (due) begin
        e = expq[ch].pop_front();
        hold_data[ch] = e.data;
        hold_fe[ch]   = e.ferr;
        hold_pe[ch]   = e.perr;
      end
      if (valid_w[ch] === 1'b1) begin
        prev_strobe[ch]      = last_strobe[ch];
        last_strobe[ch]      = cyc;
        busy_at_strobe[ch]   = busy_w[ch];
        busy_before_strb[ch] = prev_busy[ch];
      end
      prev_busy[ch] = busy_w[ch];
      chk($sformatf("ch%0d rx_valid", ch), 32'(valid_w[ch]), 32'(due));
      chk($sformatf("ch%0d rx_data", ch), 32'(data_w[ch]), 32'(hold_data[ch]));
      chk($sformatf("ch%0d frame_err", ch), 32'(ferr_w[ch]), 32'(hold_fe[ch]));
      chk($sformatf("ch%0d parity_err", ch), 32'(perr_w[ch]), 32'(hold_pe[ch]));
    end
  endtask

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive_bit(input int ch, input logic b);
    rx_line[ch] = b;
    idle(CPB);
  endtask

  task automatic wait_neg(input int unsigned t);
    do @(negedge clk_in); while (cyc < t);
  endtask

  task automatic clear_model();
    for (int ch = 0; ch < 2; ch++) begin
      expq[ch].delete();
      hold_data[ch] = 8'h00;
      hold_fe[ch]   = 1'b0;
      hold_pe[ch]   = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // Channel 1 is even parity, so the expected parity bit is the XOR of the data.
  // Strobe: 2 sync cycles to T0, HALF to the start check, (N+1) bit periods to
  // the stop sample, then one more cycle.
  task automatic send_frame(input int ch, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic stop_bit,
                            output int unsigned t_start);
    exp_t        e;
    int unsigned nbits;
    nbits   = with_par ? 9 : 8;
    t_start = cyc;
    e.cyc   = t_start + 2 + HALF + (nbits + 1) * CPB + 1;
    e.data  = d;
    e.ferr  = ~stop_bit;
    e.perr  = with_par && (par_bit != (^d));
    expq[ch].push_back(e);
    drive_bit(ch, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ch, d[i]);
    if (with_par) drive_bit(ch, par_bit);
    drive_bit(ch, stop_bit);
  endtask

  initial begin
    int unsigned t, t2;
    logic [7:0]  d55;
    n_cmp  = 0;
    n_fail = 0;
    en     = 1'b0;
    reset  = 1'b1;
    rx_line[0] = 1'b1;
    rx_line[1] = 1'b1;
    clear_model();
    for (int ch = 0; ch < 2; ch++) begin
      last_strobe[ch] = 0; prev_strobe[ch] = 0;
      busy_at_strobe[ch] = 1'b0; busy_before_strb[ch] = 1'b0; prev_busy[ch] = 1'b0;
    end
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;
    en    = 1'b1;

    fork
      forever begin
        @(negedge clk_in);
        if (en) compare_cycle();
      end
    join_none

    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("ch%0d reset rx_data", ch), 32'(data_w[ch]), 32'h00);
      chk($sformatf("ch%0d reset rx_valid", ch), 32'(valid_w[ch]), 32'h0);
      chk($sformatf("ch%0d reset busy", ch), 32'(busy_w[ch]), 32'h0);
    end
    idle(20);

    // 0xA5, no parity.
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, t);
    chk("A5 strobe latency", last_strobe[0] - t, 32'd2064);
    chk("A5 rx_data", 32'(data_w[0]), 32'hA5);
    chk("A5 frame_err", 32'(ferr_w[0]), 32'h0);
    chk("A5 busy before strobe", 32'(busy_before_strb[0]), 32'h1);
    chk("A5 busy at strobe", 32'(busy_at_strobe[0]), 32'h0);

    // 50-cycle glitch: false start, no strobe.
    idle(100);
    t = cyc;
    rx_line[0] = 1'b0;
    idle(50);
    rx_line[0] = 1'b1;
    wait_neg(t + 110);
    chk("glitch busy at start check", 32'(busy_w[0]), 32'h1);
    wait_neg(t + 111);
    chk("glitch busy after start check", 32'(busy_w[0]), 32'h0);
    @(posedge clk_in);
    #1;

    // 0x3C with a low stop bit, line then held low.
    idle(100);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, t);
    idle(1000);
    chk("break busy", 32'(busy_w[0]), 32'h1);
    chk("break rx_data", 32'(data_w[0]), 32'h3C);
    chk("break frame_err", 32'(ferr_w[0]), 32'h1);
    rx_line[0] = 1'b1;
    idle(5);
    chk("break release busy", 32'(busy_w[0]), 32'h0);
    idle(50);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, t);
    chk("after break rx_data", 32'(data_w[0]), 32'h5A);
    chk("after break frame_err", 32'(ferr_w[0]), 32'h0);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct.
    idle(50);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, t);
    chk("par bad latency", last_strobe[1] - t, 32'd2281);
    chk("par bad parity_err", 32'(perr_w[1]), 32'h1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, t);
    chk("par good parity_err", 32'(perr_w[1]), 32'h0);
    chk("par good rx_data", 32'(data_w[1]), 32'h07);

    // Back-to-back 0x00 then 0xFF.
    idle(50);
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, t);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, t2);
    chk("b2b strobe spacing", last_strobe[0] - prev_strobe[0], 32'd2170);
    chk("b2b second rx_data", 32'(data_w[0]), 32'hFF);

    // Reset during bit 4 of 0x55; the transmission is abandoned.
    idle(50);
    d55 = 8'h55;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d55[i]);
    rx_line[0] = d55[4];
    idle(100);
    chk("mid-frame busy", 32'(busy_w[0]), 32'h1);
    do_reset();
    chk("post-reset rx_data", 32'(data_w[0]), 32'h00);
    chk("post-reset busy", 32'(busy_w[0]), 32'h0);
    chk("post-reset ch1 rx_data", 32'(data_w[1]), 32'h00);
    idle(300);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, t);
    chk("0x81 rx_data", 32'(data_w[0]), 32'h81);

    idle(20);
    chk("ch0 pending expectations", expq[0].size(), 32'd0);
    chk("ch1 pending expectations", expq[1].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
